// File: rtl/ahb_pkg.sv
// AHB-Lite encodings and LSU master FSM state type, shared by the ahb_lsu_master
// block and its helper modules.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // StIdle: nothing outstanding; StData: one data phase outstanding;
  // StErr2: second cycle of an ERROR response; StMerr: local misalignment pending.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StData = 2'b01,
    StErr2 = 2'b10,
    StMerr = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/ahb_lsu_align_chk.sv
// Combinational misalignment check for an LSU access.
// Ports:
//   size_i        access size (0 byte, 1 half, 2 word, others illegal)
//   addr_i        low two bits of the byte address
//   misaligned_o  1 when the access cannot be issued on the bus
module ahb_lsu_align_chk
  import ahb_pkg::*;
(
  input  logic [2:0] size_i,
  input  logic [1:0] addr_i,
  output logic       misaligned_o
);

  always_comb begin
    misaligned_o = 1'b0;
    case (size_i)
      HSIZE_BYTE: misaligned_o = 1'b0;
      HSIZE_HALF: misaligned_o = addr_i[0];
      HSIZE_WORD: misaligned_o = |addr_i;
      default:    misaligned_o = 1'b1;  // wider than the 32-bit bus
    endcase
  end

endmodule

// File: rtl/ahb_lsu_master.sv
// AHB-Lite master bridge: turns LSU req/gnt/rvalid handshakes into pipelined
// AHB-Lite SINGLE transfers (one transfer per cycle at zero wait states).
// Handles slave wait states, the two-cycle ERROR response and local
// misalignment errors.
// Optional feature (macro AHB_LSU_MASTER_TIMEOUT_EN): abandon a data phase
// with an error response after TIMEOUT_CYCLES consecutive stalled cycles.
// Ports:
//   hclk, hreset                  clock, synchronous active-high reset
//   req_i/we_i/size_i/addr_i/wdata_i  LSU request, held until gnt_o
//   gnt_o                         request accepted (address phase done)
//   rvalid_o/rdata_o/err_o        one response pulse per grant, in order
//   haddr_o/htrans_o/hwrite_o/hsize_o/hburst_o/hwdata_o  AHB master outputs
//   hready_i/hresp_i/hrdata_i     AHB slave responses
module ahb_lsu_master
  import ahb_pkg::*;
#(
  parameter int unsigned AWIDTH         = 32,
  parameter int unsigned DWIDTH         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        size_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  output logic              gnt_o,
  output logic              rvalid_o,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              err_o,
  output logic [AWIDTH-1:0] haddr_o,
  output logic [1:0]        htrans_o,
  output logic              hwrite_o,
  output logic [2:0]        hsize_o,
  output logic [2:0]        hburst_o,
  output logic [DWIDTH-1:0] hwdata_o,
  input  logic              hready_i,
  input  logic              hresp_i,
  input  logic [DWIDTH-1:0] hrdata_i
);

  lsu_state_e        state_q, state_d;
  logic              we_q;
  logic [DWIDTH-1:0] wdata_q;
  logic [AWIDTH-1:0] haddr_q;
  logic              hwrite_q;
  logic [2:0]        hsize_q;

  logic misaligned;
  logic present;   // a new request may be shown on the bus this cycle
  logic issue;     // NONSEQ driven this cycle
  logic gnt;
  logic done;      // response pulse this cycle
  logic rsp_err;
  logic timeout;

  ahb_lsu_align_chk u_align_chk (
    .size_i       (size_i),
    .addr_i       (addr_i[1:0]),
    .misaligned_o (misaligned)
  );

`ifdef AHB_LSU_MASTER_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] stall_cnt_q;

  assign timeout = (state_q == StData) && (stall_cnt_q == CntW'(TIMEOUT_CYCLES));

  always_ff @(posedge hclk) begin
    if (hreset) begin
      stall_cnt_q <= '0;
    end else if (state_q == StData && !timeout && !hready_i && hresp_i == HRESP_OKAY) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end else begin
      stall_cnt_q <= '0;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    present = 1'b0;
    done    = 1'b0;
    rsp_err = 1'b0;

    unique case (state_q)
      StIdle: present = 1'b1;
      StData: begin
        if (timeout) begin
          done    = 1'b1;
          rsp_err = 1'b1;
          state_d = StIdle;
        end else if (hresp_i == HRESP_ERROR) begin
          // First ERROR cycle cancels any pipelined request.
          if (hready_i) begin
            done    = 1'b1;
            rsp_err = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StErr2;
          end
        end else begin
          // During wait states the next address is shown but not granted.
          present = 1'b1;
          if (hready_i) begin
            done    = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StErr2: begin
        if (hready_i) begin
          done    = 1'b1;
          rsp_err = 1'b1;
          state_d = StIdle;
        end
      end
      StMerr: begin
        done    = 1'b1;
        rsp_err = 1'b1;
        present = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    gnt   = req_i && present && hready_i && !hreset;
    issue = req_i && present && !misaligned && !hreset;
    if (hreset) begin
      done = 1'b0;
    end
    if (gnt) begin
      state_d = misaligned ? StMerr : StData;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q  <= StIdle;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hsize_q  <= HSIZE_BYTE;
    end else begin
      state_q <= state_d;
      if (gnt) begin
        we_q    <= we_i;
        wdata_q <= wdata_i;
      end
      if (issue) begin
        haddr_q  <= addr_i;
        hwrite_q <= we_i;
        hsize_q  <= size_i;
      end
    end
  end

  assign gnt_o    = gnt;
  assign rvalid_o = done;
  assign err_o    = done && rsp_err;
  assign rdata_o  = (done && !rsp_err && !we_q) ? hrdata_i : '0;
  assign htrans_o = issue ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign haddr_o  = issue ? addr_i : haddr_q;
  assign hwrite_o = issue ? we_i : hwrite_q;
  assign hsize_o  = issue ? size_i : hsize_q;
  assign hburst_o = HBURST_SINGLE;
  assign hwdata_o = wdata_q;

endmodule
